bcd_count_7seg: RTL and testbench

Two-digit decimal up/down event counter that debounces two raw push-buttons, keeps a 00–99 BCD count and produces the registered 14-bit dual seven-segment code consumed by the downstream display multiplexer on `both7seg`. Tens digit occupies `both7seg[13:7]`; ones digit occupies `both7seg[6:0]`. The block sits directly upstream of the display multiplexer and shares its clock.

---
 rtl/bcd_count_7seg.sv | 142 ++++++++++++++
 tb/tb_bcd_count_7seg.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_count_7seg.sv
// Two-digit BCD up/down event counter with debounced push-buttons and a
// registered dual seven-segment (gfedcba, active-high) output.
module bcd_count_7seg #(
  parameter int unsigned DEB_CYCLES = 750,
  parameter int unsigned CBITS      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_dn,
  input  logic        clr,
  input  logic        blank_lz,
  output logic [7:0]  count,
  output logic [13:0] both7seg,
  output logic        wrap
);

  localparam logic [CBITS-1:0] DCNT_LAST = CBITS'(DEB_CYCLES - 1);
  localparam logic [13:0]      SEG_ZERO2 = 14'h1FBF;

  // Index 0 = up button, index 1 = down button.
  logic [1:0]       w_btn;
  logic [1:0]       r_s1;
  logic [1:0]       r_s2;
  logic [1:0]       r_stable;
  logic [1:0]       r_stable_d;
  logic [1:0]       r_press;
  logic [CBITS-1:0] r_dcnt [2];

  logic [7:0]       r_count;
  logic             r_wrap;
  logic [13:0]      r_seg;

  logic [3:0]       w_tens;
  logic [3:0]       w_ones;
  logic [6:0]       w_seg_tens;
  logic [6:0]       w_seg_ones;

  assign w_btn  = {btn_dn, btn_up};
  assign w_tens = r_count[7:4];
  assign w_ones = r_count[3:0];

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Synchronizer, debounce and rising-edge press pulse for both buttons.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      r_press    <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_dcnt[i] <= '0;
      end
    end else begin
      r_s1       <= w_btn;
      r_s2       <= r_s1;
      r_stable_d <= r_stable;
      r_press    <= r_stable & ~r_stable_d;
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_s2[i] == r_stable[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DCNT_LAST) begin
          r_stable[i] <= r_s2[i];
          r_dcnt[i]   <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + CBITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (clr) begin
        r_count <= '0;
      end else if (r_press[0] && r_press[1]) begin
        r_count <= r_count;
      end else if (r_press[0]) begin
        if (w_ones == 4'd9) begin
          if (w_tens == 4'd9) begin
            r_count <= '0;
            r_wrap  <= 1'b1;
          end else begin
            r_count <= {w_tens + 4'd1, 4'd0};
          end
        end else begin
          r_count <= {w_tens, w_ones + 4'd1};
        end
      end else if (r_press[1]) begin
        if (w_ones == 4'd0) begin
          if (w_tens == 4'd0) begin
            r_count <= 8'h99;
            r_wrap  <= 1'b1;
          end else begin
            r_count <= {w_tens - 4'd1, 4'd9};
          end
        end else begin
          r_count <= {w_tens, w_ones - 4'd1};
        end
      end
    end
  end

  assign w_seg_tens = (blank_lz && (w_tens == 4'd0)) ? 7'h00 : f_seg(w_tens);
  assign w_seg_ones = f_seg(w_ones);

  // Reset forces "00" on both digits, ignoring blank_lz until release.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_seg <= SEG_ZERO2;
    end else begin
      r_seg <= {w_seg_tens, w_seg_ones};
    end
  end

  assign count    = r_count;
  assign wrap     = r_wrap;
  assign both7seg = r_seg;

endmodule

// File: tb/tb_bcd_count_7seg.sv
// Self-checking bench for bcd_count_7seg: behavioural model compared every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_bcd_count_7seg;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_dn = 1'b0;
  logic        clr = 1'b0;
  logic        blank_lz = 1'b0;
  logic [7:0]  count;
  logic [13:0] both7seg;
  logic        wrap;

  int checks = 0;
  int failures = 0;
  int wrap_seen = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  bcd_count_7seg #(
    .DEB_CYCLES(D),
    .CBITS(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_dn   (btn_dn),
    .clr      (clr),
    .blank_lz (blank_lz),
    .count    (count),
    .both7seg (both7seg),
    .wrap     (wrap)
  );

  logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Model: count as a plain integer 0..99; debounce as "last D synchronized
  // samples all disagree with the debounced level".
  int          m_val = 0;
  bit          m_wrap = 1'b0;
  logic [13:0] m_seg = 14'h1FBF;
  bit          m_s1 [2];
  bit          m_s2 [2];
  bit          m_stb [2];
  bit          m_rose [2];
  bit          m_pulse [2];
  int unsigned m_hist [2];
  int          m_nval [2];
  logic [7:0]  exp_cnt;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit raw [2];
    int t;
    int o;
    logic [6:0] st;
    int unsigned mask;
    int unsigned want;
    raw[0] = btn_up;
    raw[1] = btn_dn;
    mask = (32'd1 << D) - 1;
    if (!rst) begin
      m_val = 0;
      m_wrap = 1'b0;
      m_seg = 14'h1FBF;
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_stb[b] = 0; m_rose[b] = 0;
        m_pulse[b] = 0; m_hist[b] = 0; m_nval[b] = 0;
      end
    end else begin
      t = m_val / 10;
      o = m_val % 10;
      st = (blank_lz && t == 0) ? 7'h00 : SEG_TAB[t];
      m_seg = {st, SEG_TAB[o]};
      m_wrap = 1'b0;
      if (clr) begin
        m_val = 0;
      end else if (m_pulse[0] && m_pulse[1]) begin
        m_val = m_val;
      end else if (m_pulse[0]) begin
        m_wrap = (m_val == 99);
        m_val = (m_val + 1) % 100;
      end else if (m_pulse[1]) begin
        m_wrap = (m_val == 0);
        m_val = (m_val + 99) % 100;
      end
      for (int b = 0; b < 2; b++) begin
        m_pulse[b] = m_rose[b];
        m_rose[b] = 0;
        m_hist[b] = (m_hist[b] << 1) | {31'd0, m_s2[b]};
        if (m_nval[b] < 32) m_nval[b]++;
        want = m_stb[b] ? 32'd0 : mask;
        if (m_nval[b] >= D && (m_hist[b] & mask) == want) begin
          m_stb[b] = !m_stb[b];
          m_rose[b] = m_stb[b];
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
    end
    cmp_en = 1'b1;
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (cmp_en) begin
      exp_cnt = {4'(m_val / 10), 4'(m_val % 10)};
      check("model_count", {8'h00, count}, {8'h00, exp_cnt});
      check("model_seg", {2'b00, both7seg}, {2'b00, m_seg});
      check("model_wrap", {15'd0, wrap}, {15'd0, m_wrap});
      if (wrap === 1'b1) wrap_seen++;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press(input int b);
    if (b == 0) btn_up = 1'b1; else btn_dn = 1'b1;
    repeat (8) tick();
    btn_up = 1'b0;
    btn_dn = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    int hu;
    int hd;
    // Reset with buttons toggling
    repeat (2) begin
      tick();
      btn_up = ~btn_up;
      btn_dn = ~btn_dn;
    end
    tick();
    check("rst_count", {8'h00, count}, 16'h0000);
    check("rst_seg", {2'b00, both7seg}, 16'h1FBF);
    check("rst_wrap", {15'd0, wrap}, 16'h0000);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    check("post_rst_seg", {2'b00, both7seg}, 16'h1FBF);
    blank_lz = 1'b1;
    tick();
    check("blank_seg", {2'b00, both7seg}, 16'h003F);
    blank_lz = 1'b0;
    tick();

    // Glitch shorter than D
    btn_up = 1'b1;
    repeat (3) tick();
    btn_up = 1'b0;
    repeat (12) tick();
    check("glitch_count", {8'h00, count}, 16'h0000);

    // Held press: latency and single increment
    btn_up = 1'b1;
    repeat (7) tick();
    check("e6_count", {8'h00, count}, 16'h0000);
    tick();
    check("e7_count", {8'h00, count}, 16'h0001);
    check("e7_seg", {2'b00, both7seg}, 16'h1FBF);
    tick();
    check("e8_seg", {2'b00, both7seg}, 16'h1F86);
    repeat (11) tick();
    btn_up = 1'b0;
    repeat (10) tick();
    check("held_single", {8'h00, count}, 16'h0001);

    // Carry
    repeat (8) press(0);
    check("count_09", {8'h00, count}, 16'h0009);
    press(0);
    check("count_10", {8'h00, count}, 16'h0010);
    check("seg_10", {2'b00, both7seg}, 16'h033F);
    repeat (89) press(0);
    check("count_99", {8'h00, count}, 16'h0099);
    wrap_seen = 0;
    press(0);
    check("up_wrap_count", {8'h00, count}, 16'h0000);
    check("up_wrap_once", 16'(wrap_seen), 16'd1);

    // Down wrap
    wrap_seen = 0;
    press(1);
    check("dn_wrap_count", {8'h00, count}, 16'h0099);
    check("dn_wrap_once", 16'(wrap_seen), 16'd1);
    check("seg_99", {2'b00, both7seg}, 16'h37EF);
    press(1);
    check("count_98", {8'h00, count}, 16'h0098);

    // Simultaneous presses cancel
    wrap_seen = 0;
    btn_up = 1'b1;
    btn_dn = 1'b1;
    repeat (8) tick();
    btn_up = 1'b0;
    btn_dn = 1'b0;
    repeat (10) tick();
    check("simul_count", {8'h00, count}, 16'h0098);
    check("simul_wrap", 16'(wrap_seen), 16'd0);

    // clr, then clr beating an up pulse at 42
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    check("clr_count", {8'h00, count}, 16'h0000);
    repeat (42) press(0);
    check("count_42", {8'h00, count}, 16'h0042);
    wrap_seen = 0;
    btn_up = 1'b1;
    repeat (7) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_prio_count", {8'h00, count}, 16'h0000);
    btn_up = 1'b0;
    repeat (10) tick();
    check("clr_prio_after", {8'h00, count}, 16'h0000);
    check("clr_prio_wrap", 16'(wrap_seen), 16'd0);

    // Reset in the middle of debouncing a held down button
    btn_dn = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    repeat (2) tick();
    check("mid_rst_count", {8'h00, count}, 16'h0000);
    rst = 1'b1;
    repeat (7) tick();
    check("requal_early", {8'h00, count}, 16'h0000);
    tick();
    check("requal_count", {8'h00, count}, 16'h0099);
    btn_dn = 1'b0;
    repeat (10) tick();

    // Random phase
    hu = 0;
    hd = 0;
    for (int n = 0; n < 3000; n++) begin
      if (hu == 0) begin
        btn_up = 1'($urandom_range(0, 1));
        hu = int'($urandom_range(1, 12));
      end
      if (hd == 0) begin
        btn_dn = 1'($urandom_range(0, 1));
        hd = int'($urandom_range(1, 12));
      end
      hu--;
      hd--;
      clr = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      rst = !($urandom_range(0, 300) == 0);
      tick();
    end
    btn_up = 1'b0;
    btn_dn = 1'b0;
    clr = 1'b0;
    rst = 1'b1;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
